// File: rtl/prio_merge_pkg.sv
// Shared types and defaults for the prio_merge_arb channel merge.
package prio_merge_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N     = 4;

   // Source-index width; a single channel still gets one bit so vectors never collapse to zero width.
   function automatic int src_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_merge_arb_if.sv
// Valid/ready bundle for the N-channel merge: N input streams plus one registered output stream.
interface prio_merge_arb_if
   import prio_merge_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N,
   parameter int SRC_W = src_w(N)
);

   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [N*WIDTH-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SRC_W-1:0]   out_src;

   // master: packet-input side and downstream consumer; slave: the merge block
   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_src
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_src
   );

endinterface

// File: rtl/prio_arb_n.sv
// N-way grant logic (fixed priority or round-robin) with rr pointer; starvation counters
// are compiled in only when PRIO_MERGE_STARVE_GUARD_EN is defined.
module prio_arb_n
   import prio_merge_pkg::*;
#(
   parameter  int N            = DEF_N,
   parameter  int STARVE_LIMIT = 8,
   localparam int SRC_W        = src_w(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  mode_e            mode,
   input  logic [N-1:0]     req,
   input  logic             xfer,
   output logic [N-1:0]     gnt,
   output logic [SRC_W-1:0] gnt_idx,
   output logic             any_req
);

   if (N < 2 || N > 16 || STARVE_LIMIT < 1) begin : g_bad_params
      $error("prio_arb_n: N must be 2..16 and STARVE_LIMIT at least 1");
   end

   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] base_idx;
   logic [N-1:0]     starved;

   function automatic logic [SRC_W-1:0] lowest(input logic [N-1:0] r);
      logic [SRC_W-1:0] pick;
      pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (r[i]) pick = SRC_W'(i);
      end
      return pick;
   endfunction

   // Descending scan so the last hit is the first requester at or after p, modulo N.
   function automatic logic [SRC_W-1:0] rotate_pick(input logic [N-1:0] r,
                                                    input logic [SRC_W-1:0] p);
      logic [SRC_W-1:0] pick;
      int k;
      pick = '0;
      for (int i = N - 1; i >= 0; i--) begin
         k = (int'(p) + i) % N;
         if (r[SRC_W'(k)]) pick = SRC_W'(k);
      end
      return pick;
   endfunction

   assign any_req = |req;

   always_comb begin
      base_idx = (mode == MODE_RR) ? rotate_pick(req, rr_ptr) : lowest(req);
      gnt_idx  = (|starved) ? lowest(starved) : base_idx;
      gnt      = any_req ? (N'(1) << gnt_idx) : '0;
   end

   // Pointer only moves on an actual channel transfer in round-robin mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (xfer && mode == MODE_RR) begin
         rr_ptr <= (gnt_idx == SRC_W'(N - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
   end

`ifdef PRIO_MERGE_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] cnt [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!req[k]) begin
               cnt[k] <= '0;
            end else if (xfer) begin
               if (gnt[k])
                  cnt[k] <= '0;
               else if (cnt[k] != CNT_W'(STARVE_LIMIT))
                  cnt[k] <= cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   // A counter at the limit only matters while its channel is still requesting.
   always_comb begin
      starved = '0;
      for (int k = 0; k < N; k++) begin
         starved[k] = req[k] && (cnt[k] == CNT_W'(STARVE_LIMIT));
      end
   end
`else
   assign starved = '0;
`endif

endmodule

// File: rtl/prio_merge_arb.sv
// N-channel valid/ready merge into one registered output stage; arbitration lives in prio_arb_n.
// Optional starvation guard: PRIO_MERGE_STARVE_GUARD_EN (handled inside prio_arb_n).
module prio_merge_arb
   import prio_merge_pkg::*;
#(
   parameter  int WIDTH        = DEF_WIDTH,
   parameter  int N            = DEF_N,
   parameter  int STARVE_LIMIT = 8,
   localparam int SRC_W        = src_w(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode_rr,
   prio_merge_arb_if.slave  bus
);

   mode_e            mode;
   logic             can_load;
   logic             xfer;
   logic             any_req;
   logic [N-1:0]     gnt;
   logic [SRC_W-1:0] gnt_idx;
   logic [WIDTH-1:0] ch_data [N];

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SRC_W-1:0] out_src_q;

   assign mode = mode_e'(mode_rr);

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
   end

   prio_arb_n #(
      .N            (N),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode),
      .req     (bus.in_valid),
      .xfer    (xfer),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

   // rst_n gates ready so no channel handshake can complete while held in reset.
   assign can_load     = !out_valid_q || bus.out_ready;
   assign xfer         = rst_n && can_load && any_req;
   assign bus.in_ready = xfer ? gnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= ch_data[gnt_idx];
         out_src_q   <= gnt_idx;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_prio_merge_arb.sv
// Directed bench for prio_merge_arb (N=4, WIDTH=8): fixed priority, round-robin wrap,
// backpressure, async reset, mode switch and starvation behaviour.
module tb_prio_merge_arb;
   import prio_merge_pkg::*;

   localparam int WIDTH = 8;
   localparam int N     = 4;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic mode_rr = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prio_merge_arb_if #(.WIDTH(WIDTH), .N(N)) bus ();

   prio_merge_arb #(
      .WIDTH        (WIDTH),
      .N            (N),
      .STARVE_LIMIT (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode_rr (mode_rr),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Channel payloads: ch0=0x44, ch1=0x11, ch2=0x22, ch3=0x33
   function automatic logic [31:0] ch_byte(input int k);
      case (k)
         0:       return 32'h44;
         1:       return 32'h11;
         2:       return 32'h22;
         default: return 32'h33;
      endcase
   endfunction

   initial begin
      int exp_src;

      bus.in_valid  = '0;
      bus.in_data   = 32'h33_22_11_44;
      bus.out_ready = 1'b0;
      mode_rr       = 1'b0;
      rst_n         = 1'b0;

      #12;
      bus.in_valid = 4'b1111;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data",  32'(bus.out_data),  32'h0);
      chk("rst_out_src",   32'(bus.out_src),   32'h0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
      bus.in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // fixed priority: ch1 beats ch3 every cycle
      bus.in_valid  = 4'b1010;
      bus.out_ready = 1'b1;
      #1;
      chk("fix_ready0", 32'(bus.in_ready), 32'h2);
      repeat (2) begin
         tick();
         chk("fix_valid", 32'(bus.out_valid), 32'h1);
         chk("fix_data",  32'(bus.out_data),  32'h11);
         chk("fix_src",   32'(bus.out_src),   32'h1);
         chk("fix_ready", 32'(bus.in_ready),  32'h2);
      end
      bus.in_valid = '0;
      tick();
      chk("drain_valid", 32'(bus.out_valid), 32'h0);
      chk("drain_hold",  32'(bus.out_data),  32'h11);
      chk("drain_ready", 32'(bus.in_ready),  32'h0);

      // round-robin from rr_ptr=0 with all channels valid: 0,1,2,3,0
      mode_rr      = 1'b1;
      bus.in_valid = 4'b1111;
      #1;
      chk("rr_ready0", 32'(bus.in_ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_valid", 32'(bus.out_valid), 32'h1);
         chk("rr_src",   32'(bus.out_src),   32'(i % 4));
         chk("rr_data",  32'(bus.out_data),  ch_byte(i % 4));
      end
      bus.in_valid = '0;
      tick();

      // backpressure: 0x22 held while ch0 waits
      mode_rr       = 1'b0;
      bus.in_valid  = 4'b0100;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 4'b0001;
      repeat (3) begin
         #1;
         chk("bp_ready", 32'(bus.in_ready), 32'h0);
         tick();
         chk("bp_valid", 32'(bus.out_valid), 32'h1);
         chk("bp_data",  32'(bus.out_data),  32'h22);
         chk("bp_src",   32'(bus.out_src),   32'h2);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
      tick();
      chk("bp_load_data",  32'(bus.out_data),  32'h44);
      chk("bp_load_src",   32'(bus.out_src),   32'h0);
      chk("bp_load_valid", 32'(bus.out_valid), 32'h1);

      // async reset while the output holds a word (rr_ptr was 1 before this)
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("mid_rst_data",  32'(bus.out_data),  32'h0);
      chk("mid_rst_src",   32'(bus.out_src),   32'h0);
      chk("mid_rst_ready", 32'(bus.in_ready),  32'h0);
      mode_rr      = 1'b1;
      bus.in_valid = 4'b1111;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'h1);

      // three rr grants, then fixed, then back to rr at rr_ptr=3
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sw_rr_src", 32'(bus.out_src), 32'(i));
      end
      mode_rr      = 1'b0;
      bus.in_valid = 4'b0110;
      #1;
      chk("sw_fix_ready", 32'(bus.in_ready), 32'h2);
      tick();
      chk("sw_fix_src",  32'(bus.out_src),  32'h1);
      chk("sw_fix_data", 32'(bus.out_data), 32'h11);
      mode_rr      = 1'b1;
      bus.in_valid = 4'b1111;
      #1;
      chk("sw_back_ready", 32'(bus.in_ready), 32'h8);
      tick();
      chk("sw_back_src",  32'(bus.out_src),  32'h3);
      chk("sw_back_data", 32'(bus.out_data), 32'h33);
      chk("sw_wrap_ready", 32'(bus.in_ready), 32'h1);
      tick();
      chk("sw_wrap_src", 32'(bus.out_src), 32'h0);

      // starvation: fixed mode, ch0 and ch3 always valid
      bus.in_valid = '0;
      tick();
      mode_rr      = 1'b0;
      bus.in_valid = 4'b1001;
      for (int i = 0; i < 18; i++) begin
         tick();
`ifdef PRIO_MERGE_STARVE_GUARD_EN
         exp_src = ((i % 9) == 8) ? 3 : 0;
`else
         exp_src = 0;
`endif
         chk("starve_src",   32'(bus.out_src),   32'(exp_src));
         chk("starve_valid", 32'(bus.out_valid), 32'h1);
      end

      bus.in_valid = '0;
      tick();
      chk("final_drain", 32'(bus.out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
